// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared VGA timing, grid geometry and step-scheduler state encoding
package game_pkg;

   localparam int VGA_TOTAL_COLS  = 800;
   localparam int VGA_TOTAL_ROWS  = 525;
   localparam int VGA_ACTIVE_COLS = 640;
   localparam int VGA_ACTIVE_ROWS = 480;

   localparam int GRID_COLS = 40;
   localparam int GRID_ROWS = 30;
   localparam int CELL_PX   = 16;

   localparam int STEP_DIV_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_STEP  = 2'd2
   } step_state_t;

endpackage

// File: rtl/vga_raster_events.sv
// rtl/vga_raster_events.sv - registered frame-start, blanking-window and end-of-blanking decode
module vga_raster_events
   import game_pkg::*;
#(
   parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
   parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS
)(
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [9:0] i_Col_Count,
   input  logic [9:0] i_Row_Count,
   output logic       o_Frame_Start,
   output logic       o_Window,
   output logic       o_Blank_End
);

   localparam logic [9:0] ROW_FIRST_BLANK = 10'(ACTIVE_ROWS);
   localparam logic [9:0] ROW_LAST        = 10'(TOTAL_ROWS - 1);
   localparam logic [9:0] COL_LAST        = 10'(TOTAL_COLS - 1);

   logic r_frame_start;
   logic r_window;
   logic r_blank_end;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_frame_start <= 1'b0;
         r_window      <= 1'b0;
         r_blank_end   <= 1'b0;
      end else begin
         r_frame_start <= (i_Row_Count == ROW_FIRST_BLANK) && (i_Col_Count == 10'd0);
         r_window      <= (i_Row_Count >= ROW_FIRST_BLANK);
         r_blank_end   <= (i_Row_Count == ROW_LAST) && (i_Col_Count == COL_LAST);
      end
   end

   assign o_Frame_Start = r_frame_start;
   assign o_Window      = r_window;
   assign o_Blank_End   = r_blank_end;

endmodule

// File: rtl/game_step_scheduler.sv
// rtl/game_step_scheduler.sv - issues one game-core step handshake every N frames inside vertical blanking
module game_step_scheduler
   import game_pkg::*;
#(
   parameter int TOTAL_COLS      = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS      = VGA_TOTAL_ROWS,
   parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
   parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
   parameter int FRAMES_PER_STEP = 6
)(
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [9:0] i_Col_Count,
   input  logic [9:0] i_Row_Count,
   input  logic       i_Enable,
   output logic       o_Frame_Start,
   output logic       o_Update_Window,
   output logic       o_Step_Req,
   input  logic       i_Step_Done,
   output logic       o_Step_Abort,
   output logic       o_Overrun,
   output logic [7:0] o_Frame_Count
);

   localparam logic [STEP_DIV_W-1:0] DIV_RELOAD = STEP_DIV_W'(FRAMES_PER_STEP - 1);

   if (ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS ||
       FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255) begin : g_param_check
      $error("game_step_scheduler: illegal raster or step parameters");
   end

   step_state_t            r_state;
   step_state_t            w_next_state;
   logic [STEP_DIV_W-1:0]  r_div;
   logic [STEP_DIV_W-1:0]  w_next_div;
   logic [STEP_DIV_W-1:0]  w_div_counted;
   logic                   w_div_expired;
   logic                   w_abort;
   logic                   r_abort;
   logic                   r_overrun;
   logic [7:0]             r_frame_count;
   logic                   w_frame_start;
   logic                   w_window;
   logic                   w_blank_end;

   vga_raster_events #(
      .TOTAL_COLS  (TOTAL_COLS),
      .TOTAL_ROWS  (TOTAL_ROWS),
      .ACTIVE_ROWS (ACTIVE_ROWS)
   ) u_raster_events (
      .i_Clk         (i_Clk),
      .i_Reset       (i_Reset),
      .i_Col_Count   (i_Col_Count),
      .i_Row_Count   (i_Row_Count),
      .o_Frame_Start (w_frame_start),
      .o_Window      (w_window),
      .o_Blank_End   (w_blank_end)
   );

   // Divider value after one frame start: wraps back to the reload value at zero.
   assign w_div_expired = (r_div == '0);
   assign w_div_counted = w_div_expired ? DIV_RELOAD : (r_div - 1'b1);

   always_comb begin
      w_next_state = r_state;
      w_next_div   = r_div;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_div = DIV_RELOAD;
            if (i_Enable) w_next_state = ST_COUNT;
         end
         ST_COUNT: begin
            if (!i_Enable) begin
               w_next_state = ST_IDLE;
               w_next_div   = DIV_RELOAD;
            end else if (w_frame_start) begin
               w_next_div = w_div_counted;
               if (w_div_expired) w_next_state = ST_STEP;
            end
         end
         ST_STEP: begin
            if (w_frame_start) w_next_div = w_div_counted;
            // Done takes priority so a step finishing on the last blank cycle is not an overrun.
            if (i_Step_Done) begin
               w_next_state = ST_COUNT;
            end else if (w_blank_end) begin
               w_next_state = ST_COUNT;
               w_abort      = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_div   = DIV_RELOAD;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state       <= ST_IDLE;
         r_div         <= DIV_RELOAD;
         r_abort       <= 1'b0;
         r_overrun     <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_state   <= w_next_state;
         r_div     <= w_next_div;
         r_abort   <= w_abort;
         r_overrun <= r_overrun | w_abort;
         if (w_frame_start) r_frame_count <= r_frame_count + 8'd1;
      end
   end

   assign o_Frame_Start   = w_frame_start;
   assign o_Update_Window = w_window;
   assign o_Step_Req      = (r_state == ST_STEP);
   assign o_Step_Abort    = r_abort;
   assign o_Overrun       = r_overrun;
   assign o_Frame_Count   = r_frame_count;

endmodule

// File: tb/tb_game_step_scheduler.sv
// tb/tb_game_step_scheduler.sv - bench for game_step_scheduler on a shrunken raster
module tb_game_step_scheduler;

   localparam int TC = 10;
   localparam int TR = 8;
   localparam int AC = 6;
   localparam int AR = 5;
   localparam logic [9:0] FS_ROW   = 10'(AR);
   localparam logic [9:0] LAST_ROW = 10'(TR - 1);
   localparam logic [9:0] LAST_COL = 10'(TC - 1);
   localparam int M_OFF  = 0;
   localparam int M_WAIT = 1;
   localparam int M_REQ  = 2;
   localparam int NV     = 10;

   typedef struct {
      int         f;
      int         mode;
      int         cnt;
      logic       abort;
      logic       over;
      logic [7:0] fc;
   } model_t;

   typedef struct {
      logic [9:0] row;
      logic [9:0] col;
      logic       fs;
      logic       win;
      logic [7:0] fc;
   } vec_t;

   logic       clk, rst, en6, en1, done6, done1;
   logic [9:0] row, col;
   logic       fs6, win6, req6, ab6, ov6;
   logic       fs1, win1, req1, ab1, ov1;
   logic [7:0] fc6, fc1;

   int     checks, failures, cyc;
   logic   chk_on, gen_on, e_fs, e_win, e_be, fs6_d, prev_req6, prev_req1;
   int     rsp_mode, rsp_cnt, rsp_lim, rises6, aborts6, rises1, hi1;
   model_t m6, m1;
   vec_t   vec [NV];

   game_step_scheduler #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
                         .ACTIVE_ROWS(AR), .FRAMES_PER_STEP(6)) dut6 (
      .i_Clk(clk), .i_Reset(rst), .i_Col_Count(col), .i_Row_Count(row), .i_Enable(en6),
      .o_Frame_Start(fs6), .o_Update_Window(win6), .o_Step_Req(req6), .i_Step_Done(done6),
      .o_Step_Abort(ab6), .o_Overrun(ov6), .o_Frame_Count(fc6));

   game_step_scheduler #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
                         .ACTIVE_ROWS(AR), .FRAMES_PER_STEP(1)) dut1 (
      .i_Clk(clk), .i_Reset(rst), .i_Col_Count(col), .i_Row_Count(row), .i_Enable(en1),
      .o_Frame_Start(fs1), .o_Update_Window(win1), .o_Step_Req(req1), .i_Step_Done(done1),
      .o_Step_Abort(ab1), .o_Overrun(ov1), .o_Frame_Count(fc1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   // Step bookkeeping: a step is due whenever the number of frame starts seen since enabling is a multiple of f.
   task automatic model_edge(inout model_t m, input logic r, input logic en, input logic done,
                             input logic fs, input logic be);
      if (r) begin
         m.mode = M_OFF; m.cnt = 0; m.abort = 1'b0; m.over = 1'b0; m.fc = 8'd0;
         return;
      end
      m.abort = 1'b0;
      if (fs) m.fc = m.fc + 8'd1;
      if (m.mode == M_OFF) begin
         if (en) begin m.mode = M_WAIT; m.cnt = 0; end
      end else if (m.mode == M_WAIT) begin
         if (!en) m.mode = M_OFF;
         else if (fs) begin
            m.cnt++;
            if (m.cnt % m.f == 0) m.mode = M_REQ;
         end
      end else begin
         if (fs) m.cnt++;
         if (done) m.mode = M_WAIT;
         else if (be) begin m.mode = M_WAIT; m.abort = 1'b1; m.over = 1'b1; end
      end
   endtask

   task automatic tick();
      fs6_d = fs6;
      @(posedge clk);
      model_edge(m6, rst, en6, done6, e_fs, e_be);
      model_edge(m1, rst, en1, done1, e_fs, e_be);
      if (rst) begin
         e_fs = 1'b0; e_win = 1'b0; e_be = 1'b0;
      end else begin
         e_fs  = (row == FS_ROW) && (col == 10'd0);
         e_win = (row >= FS_ROW);
         e_be  = (row == LAST_ROW) && (col == LAST_COL);
      end
      #1;
      if (gen_on) begin
         if (col == LAST_COL) begin
            col = 10'd0;
            row = (row == LAST_ROW) ? 10'd0 : row + 10'd1;
         end else col = col + 10'd1;
      end
      if (rsp_mode == 0) done6 = 1'b0;
      else if (rsp_mode == 1 || rsp_mode == 2) begin
         if (done6) begin done6 = 1'b0; rsp_cnt = 0; end
         else if (req6) begin
            if (rsp_cnt == 0) rsp_lim = (rsp_mode == 1) ? 10 : int'($urandom_range(1, 40));
            rsp_cnt++;
            if (rsp_cnt >= rsp_lim) done6 = 1'b1;
         end else begin
            rsp_cnt = 0;
            if (rsp_mode == 2 && $urandom_range(0, 15) == 0) done6 = 1'b1;
         end
      end
      @(negedge clk);
      cyc++;
      if (req6 && !prev_req6) rises6++;
      if (req1 && !prev_req1) rises1++;
      if (req1) hi1++;
      if (ab6) aborts6++;
      prev_req6 = req6;
      prev_req1 = req1;
      if (chk_on) begin
         check("cycle_dut6", {fs6, win6, req6, ab6, ov6, fc6},
               {e_fs, e_win, m6.mode == M_REQ, m6.abort, m6.over, m6.fc});
         check("cycle_dut1", {fs1, win1, req1, ab1, ov1, fc1},
               {e_fs, e_win, m1.mode == M_REQ, m1.abort, m1.over, m1.fc});
      end
   endtask

   task automatic wait_rise(input int bound, output int nfs, output logic ok);
      int r0;
      r0  = rises6;
      nfs = 0;
      ok  = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (fs6) nfs++;
         if (rises6 != r0) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      int   n;
      logic ok;
      vec[0] = '{10'd0, 10'd0, 1'b0, 1'b0, 8'd0};
      vec[1] = '{10'd4, 10'd9, 1'b0, 1'b0, 8'd0};
      vec[2] = '{10'd5, 10'd0, 1'b1, 1'b1, 8'd0};
      vec[3] = '{10'd5, 10'd1, 1'b0, 1'b1, 8'd1};
      vec[4] = '{10'd6, 10'd0, 1'b0, 1'b1, 8'd1};
      vec[5] = '{10'd7, 10'd9, 1'b0, 1'b1, 8'd1};
      vec[6] = '{10'd5, 10'd0, 1'b1, 1'b1, 8'd1};
      vec[7] = '{10'd0, 10'd5, 1'b0, 1'b0, 8'd2};
      vec[8] = '{10'd4, 10'd0, 1'b0, 1'b0, 8'd2};
      vec[9] = '{10'd9, 10'd3, 1'b0, 1'b1, 8'd2};

      checks = 0; failures = 0; cyc = 0;
      rst = 1'b1; en6 = 1'b0; en1 = 1'b0; done6 = 1'b0; done1 = 1'b0;
      row = 10'd0; col = 10'd0; gen_on = 1'b0; rsp_mode = 3; rsp_cnt = 0; rsp_lim = 0;
      rises6 = 0; aborts6 = 0; rises1 = 0; hi1 = 0; prev_req6 = 1'b0; prev_req1 = 1'b0;
      e_fs = 1'b0; e_win = 1'b0; e_be = 1'b0; fs6_d = 1'b0;
      m6 = '{6, M_OFF, 0, 1'b0, 1'b0, 8'd0};
      m1 = '{1, M_OFF, 0, 1'b0, 1'b0, 8'd0};
      chk_on = 1'b1;

      tick(); tick();
      check("reset_req", 13'(req6), 13'd0);
      check("reset_flags", {ab6, ov6, fs6, win6, 9'd0}, 13'd0);
      check("reset_fc", 13'(fc6), 13'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         row = vec[i].row;
         col = vec[i].col;
         tick();
         check("table_frame_start", 13'(fs6), 13'(vec[i].fs));
         check("table_window", 13'(win6), 13'(vec[i].win));
         check("table_frame_count", 13'(fc6), 13'(vec[i].fc));
      end

      // Six-frame cadence with done returned a fixed delay after each request.
      rst = 1'b1; row = 10'd0; col = 10'd0;
      tick();
      rst = 1'b0; en6 = 1'b1; en1 = 1'b1; done1 = 1'b1; rsp_mode = 1; gen_on = 1'b1;
      rises1 = 0; hi1 = 0; aborts6 = 0;
      for (int k = 0; k < 3; k++) begin
         wait_rise(700, n, ok);
         check("cadence_timeout", 13'(ok), 13'd1);
         check("cadence_frames", 13'(n), 13'd6);
         check("cadence_after_fs", 13'(fs6_d), 13'd1);
      end
      for (int i = 0; i < 20; i++) tick();
      check("cadence_frame_count", 13'(fc6), 13'd18);
      check("cadence_aborts", 13'(aborts6), 13'd0);
      check("div1_requests", 13'(rises1), 13'd18);
      check("div1_req_cycles", 13'(hi1), 13'd18);

      // Done coincides with the end-of-blanking event.
      rsp_mode = 3; done6 = 1'b0;
      wait_rise(700, n, ok);
      check("same_cycle_timeout", 13'(ok), 13'd1);
      for (int i = 0; i < 100 && !(row == LAST_ROW && col == LAST_COL); i++) tick();
      tick();
      done6 = 1'b1;
      tick();
      done6 = 1'b0;
      check("same_cycle_req", 13'(req6), 13'd0);
      check("same_cycle_abort", 13'(ab6), 13'd0);
      check("same_cycle_overrun", 13'(ov6), 13'd0);
      tick();
      check("same_cycle_abort_late", 13'(ab6), 13'd0);

      // Done never returned: abort at end of blanking, then the cadence resumes.
      rsp_mode = 0;
      wait_rise(700, n, ok);
      check("never_timeout", 13'(ok), 13'd1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ab6) begin ok = 1'b1; break; end
      end
      check("never_abort_seen", 13'(ok), 13'd1);
      check("never_abort_position", {row == 10'd0, col == 10'd1, 11'd0}, {2'b11, 11'd0});
      check("never_req_dropped", 13'(req6), 13'd0);
      check("never_overrun", 13'(ov6), 13'd1);
      rsp_mode = 1;
      tick();
      check("never_abort_width", 13'(ab6), 13'd0);
      wait_rise(700, n, ok);
      check("never_next_frames", 13'(n), 13'd6);
      check("never_overrun_sticky", 13'(ov6), 13'd1);

      // Enable dropped mid-step: request held until done, then idle.
      rsp_mode = 3; done6 = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      wait_rise(700, n, ok);
      check("endrop_timeout", 13'(ok), 13'd1);
      tick(); tick(); tick();
      en6 = 1'b0;
      tick(); tick(); tick();
      check("endrop_req_held", 13'(req6), 13'd1);
      done6 = 1'b1;
      tick();
      done6 = 1'b0;
      check("endrop_req_dropped", 13'(req6), 13'd0);
      n = rises6;
      for (int i = 0; i < 8 * TC * TR; i++) tick();
      check("endrop_no_requests", 13'(rises6 - n), 13'd0);
      rsp_mode = 1;
      en6 = 1'b1;
      wait_rise(700, n, ok);
      check("reenable_frames", 13'(n), 13'd6);

      // Reset while a step is in flight.
      for (int i = 0; i < 30; i++) tick();
      rsp_mode = 3; done6 = 1'b0;
      wait_rise(700, n, ok);
      check("rststep_timeout", 13'(ok), 13'd1);
      tick(); tick();
      rst = 1'b1;
      tick();
      check("rststep_dut6", {fs6, win6, req6, ab6, ov6, fc6}, 13'd0);
      check("rststep_dut1", {fs1, win1, req1, ab1, ov1, fc1}, 13'd0);
      rst = 1'b0;

      // Random enable and done timing against the model, through a frame-counter wrap.
      rsp_mode = 2;
      n = 0; ok = 1'b0;
      for (int i = 0; i < 256 * TC * TR + 400; i++) begin
         if ($urandom_range(0, 199) == 0) en6 = ~en6;
         tick();
         if (fs6) begin
            n++;
            if (n == 256) begin ok = 1'b1; break; end
         end
      end
      check("wrap_timeout", 13'(ok), 13'd1);
      check("wrap_before", 13'(fc6), 13'd255);
      tick();
      check("wrap_after", 13'(fc6), 13'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
